lc3b_mem_arbiter: RTL and testbench
===================================

Name: lc3b_mem_arbiter

Overview:
- Shares the single LC-3b physical memory port between two requesters: the instruction-fetch path (I) and the load/store data path (D).
- Sits between the datapath/control and memory.
- Serialises transactions with a registered grant FSM and supports round-robin or fixed D-priority arbitration.
- Memory-side handshake is unchanged: the command is held until mem_resp.

Parameters:
- FIXED_PRIORITY, 0, 0 = round-robin on contention; 1 = D always wins on contention.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- i_read  in  1  instruction fetch request, held until i_resp
- i_address  in  16 (lc3b_word)  fetch address
- i_rdata  out  16 (lc3b_word)  fetch data, valid when i_resp=1
- i_resp  out  1  fetch complete, one-cycle pulse
- d_read  in  1  data read request, held until d_resp
- d_write  in  1  data write request, held until d_resp
- d_wmask  in  2 (lc3b_mem_wmask)  byte write enables
- d_address  in  16 (lc3b_word)  data address
- d_wdata  in  16 (lc3b_word)  write data
- d_rdata  out  16 (lc3b_word)  read data, valid when d_resp=1
- d_resp  out  1  data access complete, one-cycle pulse
- mem_read  out  1  memory read command
- mem_write  out  1  memory write command
- mem_wmask  out  2 (lc3b_mem_wmask)  memory byte enables
- mem_address  out  16 (lc3b_word)  memory address
- mem_wdata  out  16 (lc3b_word)  memory write data
- mem_rdata  in  16 (lc3b_word)  memory read data
- mem_resp  in  1  memory completion, one-cycle pulse

Behaviour:
- States: IDLE, GRANT_I, GRANT_D. There is also a 1-bit last_grant register (0 = I, 1 = D).
- Reset (sync, any state, including mid-transaction):
  - State goes to IDLE and last_grant to D, so I wins the first contention.
  - mem_read, mem_write, i_resp and d_resp read 0.
  - mem_address, mem_wdata and mem_wmask read 0.
  - An in-flight mem_resp is dropped, with no resp to either requester.
- IDLE:
  - All mem_* commands are 0.
  - Arbitration uses d_req = d_read | d_write.
    - Only i_read: next state GRANT_I.
    - Only d_req: next state GRANT_D.
    - Both, FIXED_PRIORITY=1: GRANT_D.
    - Both, FIXED_PRIORITY=0: grant the requester opposite to last_grant.
    - Neither: stay in IDLE.
  - mem_resp seen in IDLE is ignored.
- GRANT_I:
  - mem_read=1, mem_write=0, mem_address=i_address, mem_wmask=0, mem_wdata=0.
  - On mem_resp: i_resp=1 and i_rdata=mem_rdata in the same cycle (combinational pass-through). Next state IDLE, last_grant set to I.
- GRANT_D:
  - mem_address=d_address, mem_wdata=d_wdata, mem_wmask=d_wmask.
  - mem_write=d_write, and mem_read=d_read & ~d_write. d_read and d_write asserted together is a protocol error; the write wins.
  - On mem_resp: d_resp=1 and d_rdata=mem_rdata the same cycle. Next state IDLE, last_grant set to D.
- Responses:
  - i_rdata/d_rdata equal mem_rdata whenever their resp is 1; otherwise 0.
  - i_resp and d_resp are never asserted in the same cycle.
- Latency:
  - Request seen in IDLE at cycle N; command on mem_* from cycle N+1.
  - Response in the mem_resp cycle.
  - A mandatory one-cycle IDLE bubble follows every completion, so a requester deasserting after resp is never re-granted a stale request.
  - Minimum turnaround for back-to-back requests is mem latency + 2 cycles.
- Grant stability:
  - Once granted, the grant holds until mem_resp even if the requester drops its request. Dropping early is illegal and the block does not abort.
  - A competing request never preempts the current grant.
- No starvation: with FIXED_PRIORITY=0 and both requesting continuously, grants strictly alternate.

Decomposition:
- Add to lc3b_types: typedef enum lc3b_arb_state {arb_idle, arb_grant_i, arb_grant_d}.
- Reuse the existing lc3b_word and lc3b_mem_wmask.
- One natural sub-module, lc3b_arb_control: the FSM plus the last_grant register, outputting the state/grant select.
- The top level holds the mem_* output muxing and the resp/rdata steering.

Test Plan:
- Reset mid-transaction: assert rst during GRANT_D with mem_write=1 -> next cycle all mem_* 0, state IDLE. A mem_resp in the following cycle produces no d_resp.
- Single fetch: i_read=1, i_address=16'h0060, mem_resp after 3 cycles with mem_rdata=16'h1234 -> mem_read high from cycle 1, mem_address=16'h0060; i_resp=1 with i_rdata=16'h1234 in the resp cycle; then one IDLE cycle.
- Byte write: d_write=1, d_wmask=2'b10, d_address=16'h0101, d_wdata=16'hAB00 -> mem_write=1, mem_wmask=2'b10, mem_wdata=16'hAB00, mem_read=0; d_resp on mem_resp; i_resp stays 0.
- Round-robin contention (FIXED_PRIORITY=0): after reset, i_read and d_read both held high across 4 transactions -> grant order I, D, I, D. Each grant is followed by exactly one IDLE cycle.
- Fixed priority (FIXED_PRIORITY=1): both requests held high -> D granted every time while d_req=1; I granted only after D drops.
- Protocol errors: in GRANT_I, i_read drops before mem_resp -> mem_read stays 1 and i_resp still fires. With d_read=d_write=1 -> mem_write=1 and mem_read=0.

Source files
------------

// File: rtl/lc3b_mem_arbiter_pkg.sv
// rtl/lc3b_mem_arbiter_pkg.sv - shared LC-3b word, byte-mask and arbiter state types
package lc3b_mem_arbiter_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    arb_idle,
    arb_grant_i,
    arb_grant_d
  } lc3b_arb_state;

endpackage

// File: rtl/lc3b_mem_arbiter_control.sv
// rtl/lc3b_mem_arbiter_control.sv - grant FSM and last-grant register for the memory arbiter
module lc3b_arb_control
  import lc3b_mem_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_fetch_req,
  input  logic          i_data_req,
  input  logic          i_mem_resp,
  output lc3b_arb_state o_state
);

  lc3b_arb_state r_state;
  logic          r_last_grant;

  assign o_state = r_state;

  // Every completion returns to idle, giving the one-cycle bubble before the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= arb_idle;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        arb_idle: begin
          if (i_fetch_req && i_data_req) begin
            if (FIXED_PRIORITY || !r_last_grant) r_state <= arb_grant_d;
            else                                 r_state <= arb_grant_i;
          end else if (i_fetch_req) begin
            r_state <= arb_grant_i;
          end else if (i_data_req) begin
            r_state <= arb_grant_d;
          end
        end
        arb_grant_i: begin
          if (i_mem_resp) begin
            r_state      <= arb_idle;
            r_last_grant <= 1'b0;
          end
        end
        arb_grant_d: begin
          if (i_mem_resp) begin
            r_state      <= arb_idle;
            r_last_grant <= 1'b1;
          end
        end
        default: r_state <= arb_idle;
      endcase
    end
  end

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// rtl/lc3b_mem_arbiter.sv - shares the LC-3b memory port between fetch and data paths
module lc3b_mem_arbiter
  import lc3b_mem_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_read,
  input  lc3b_word      i_address,
  output lc3b_word      i_rdata,
  output logic          i_resp,
  input  logic          d_read,
  input  logic          d_write,
  input  lc3b_mem_wmask d_wmask,
  input  lc3b_word      d_address,
  input  lc3b_word      d_wdata,
  output lc3b_word      d_rdata,
  output logic          d_resp,
  output logic          mem_read,
  output logic          mem_write,
  output lc3b_mem_wmask mem_wmask,
  output lc3b_word      mem_address,
  output lc3b_word      mem_wdata,
  input  lc3b_word      mem_rdata,
  input  logic          mem_resp
);

  lc3b_arb_state w_state;
  logic          w_gnt_i;
  logic          w_gnt_d;

  lc3b_arb_control #(
    .FIXED_PRIORITY(FIXED_PRIORITY)
  ) u_control (
    .clk        (clk),
    .rst        (rst),
    .i_fetch_req(i_read),
    .i_data_req (d_read | d_write),
    .i_mem_resp (mem_resp),
    .o_state    (w_state)
  );

  // Reset forces every command and response low in its own cycle, dropping any in-flight resp.
  assign w_gnt_i = (w_state == arb_grant_i) && !rst;
  assign w_gnt_d = (w_state == arb_grant_d) && !rst;

  // A simultaneous read and write from the data path is treated as a write.
  assign mem_read    = w_gnt_i | (w_gnt_d & d_read & ~d_write);
  assign mem_write   = w_gnt_d & d_write;
  assign mem_wmask   = w_gnt_d ? d_wmask : '0;
  assign mem_wdata   = w_gnt_d ? d_wdata : '0;
  assign mem_address = w_gnt_i ? i_address : (w_gnt_d ? d_address : '0);

  assign i_resp  = w_gnt_i & mem_resp;
  assign d_resp  = w_gnt_d & mem_resp;
  assign i_rdata = i_resp ? mem_rdata : '0;
  assign d_rdata = d_resp ? mem_rdata : '0;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// tb/tb_lc3b_mem_arbiter.sv - directed bench for round-robin and fixed-priority arbiters
module tb_lc3b_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read, d_read, d_write, mem_resp;
  logic [15:0] i_address, d_address, d_wdata, mem_rdata;
  logic [1:0]  d_wmask;

  logic [15:0] i_rdata_rr, d_rdata_rr, mem_address_rr, mem_wdata_rr;
  logic        i_resp_rr, d_resp_rr, mem_read_rr, mem_write_rr;
  logic [1:0]  mem_wmask_rr;
  logic [15:0] i_rdata_fp, d_rdata_fp, mem_address_fp, mem_wdata_fp;
  logic        i_resp_fp, d_resp_fp, mem_read_fp, mem_write_fp;
  logic [1:0]  mem_wmask_fp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lc3b_mem_arbiter dut_rr (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata_rr), .i_resp(i_resp_rr),
    .d_read(d_read), .d_write(d_write), .d_wmask(d_wmask), .d_address(d_address),
    .d_wdata(d_wdata), .d_rdata(d_rdata_rr), .d_resp(d_resp_rr),
    .mem_read(mem_read_rr), .mem_write(mem_write_rr), .mem_wmask(mem_wmask_rr),
    .mem_address(mem_address_rr), .mem_wdata(mem_wdata_rr),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  lc3b_mem_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata_fp), .i_resp(i_resp_fp),
    .d_read(d_read), .d_write(d_write), .d_wmask(d_wmask), .d_address(d_address),
    .d_wdata(d_wdata), .d_rdata(d_rdata_fp), .d_resp(d_resp_fp),
    .mem_read(mem_read_fp), .mem_write(mem_write_fp), .mem_wmask(mem_wmask_fp),
    .mem_address(mem_address_fp), .mem_wdata(mem_wdata_fp),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    i_address = 0; d_address = 0; d_wdata = 0; mem_rdata = 0; d_wmask = 0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if ({mem_read_rr, mem_write_rr, i_resp_rr, d_resp_rr} !== 4'b0) begin
      bad++; $display("FAIL reset_ctrl got %b want 0000", {mem_read_rr, mem_write_rr, i_resp_rr, d_resp_rr});
    end
    total++;
    if ({mem_address_rr, mem_wdata_rr, mem_wmask_rr} !== 34'h0) begin
      bad++; $display("FAIL reset_data got %h want 0", {mem_address_rr, mem_wdata_rr, mem_wmask_rr});
    end
  endtask

  task automatic test_reset_mid_txn();
    do_reset();
    d_write = 1; d_address = 16'h0200; d_wdata = 16'h5555; d_wmask = 2'b11;
    step(); #1;
    total++;
    if (mem_write_rr !== 1'b1) begin
      bad++; $display("FAIL midrst_write got %b want 1", mem_write_rr);
    end
    step(); rst = 1'b1; d_write = 0;
    step(); rst = 1'b0; #1;
    total++;
    if ({mem_read_rr, mem_write_rr, mem_address_rr, mem_wdata_rr, mem_wmask_rr} !== 36'h0) begin
      bad++; $display("FAIL midrst_idle got %h want 0", {mem_read_rr, mem_write_rr, mem_address_rr, mem_wdata_rr, mem_wmask_rr});
    end
    mem_resp = 1; mem_rdata = 16'hDEAD; #1;
    total++;
    if ({d_resp_rr, i_resp_rr, d_rdata_rr} !== 18'h0) begin
      bad++; $display("FAIL midrst_resp got %h want 0", {d_resp_rr, i_resp_rr, d_rdata_rr});
    end
    step(); mem_resp = 0;
  endtask

  task automatic test_single_fetch();
    do_reset();
    i_read = 1; i_address = 16'h0060;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) begin mem_resp = 1; mem_rdata = 16'h1234; end
      #1;
      total++;
      if (mem_read_rr !== 1'b1 || mem_address_rr !== 16'h0060) begin
        bad++; $display("FAIL fetch_cmd c%0d got rd=%b a=%h want rd=1 a=0060", c, mem_read_rr, mem_address_rr);
      end
      total++;
      if (i_resp_rr !== (c == 3) || i_rdata_rr !== ((c == 3) ? 16'h1234 : 16'h0)) begin
        bad++; $display("FAIL fetch_resp c%0d got r=%b d=%h", c, i_resp_rr, i_rdata_rr);
      end
    end
    step(); mem_resp = 0; i_read = 0; #1;
    total++;
    if ({mem_read_rr, i_resp_rr, mem_address_rr} !== 18'h0) begin
      bad++; $display("FAIL fetch_idle got %h want 0", {mem_read_rr, i_resp_rr, mem_address_rr});
    end
  endtask

  task automatic test_byte_write();
    do_reset();
    d_write = 1; d_wmask = 2'b10; d_address = 16'h0101; d_wdata = 16'hAB00;
    step(); #1;
    total++;
    if ({mem_write_rr, mem_read_rr, mem_wmask_rr, mem_address_rr, mem_wdata_rr} !== {1'b1, 1'b0, 2'b10, 16'h0101, 16'hAB00}) begin
      bad++; $display("FAIL bwrite_cmd got w=%b r=%b m=%b a=%h d=%h", mem_write_rr, mem_read_rr, mem_wmask_rr, mem_address_rr, mem_wdata_rr);
    end
    step(); mem_resp = 1; #1;
    total++;
    if (d_resp_rr !== 1'b1 || i_resp_rr !== 1'b0) begin
      bad++; $display("FAIL bwrite_resp got d=%b i=%b want d=1 i=0", d_resp_rr, i_resp_rr);
    end
    step(); mem_resp = 0; d_write = 0;
  endtask

  task automatic test_round_robin();
    logic want_i;
    do_reset();
    i_read = 1; i_address = 16'h1000; d_read = 1; d_address = 16'h2000;
    for (int t = 0; t < 4; t++) begin
      want_i = (t % 2 == 0);
      step(); #1;
      total++;
      if (mem_read_rr !== 1'b1 || mem_address_rr !== (want_i ? 16'h1000 : 16'h2000)) begin
        bad++; $display("FAIL rr_grant t%0d got a=%h want %h", t, mem_address_rr, want_i ? 16'h1000 : 16'h2000);
      end
      step(); mem_resp = 1; mem_rdata = 16'h00A0 + 16'(t); #1;
      total++;
      if (i_resp_rr !== want_i || d_resp_rr !== !want_i) begin
        bad++; $display("FAIL rr_resp t%0d got i=%b d=%b want i=%b", t, i_resp_rr, d_resp_rr, want_i);
      end
      step(); mem_resp = 0; #1;
      total++;
      if ({mem_read_rr, mem_write_rr, mem_address_rr} !== 18'h0) begin
        bad++; $display("FAIL rr_bubble t%0d got %h want 0", t, {mem_read_rr, mem_write_rr, mem_address_rr});
      end
    end
    i_read = 0; d_read = 0;
  endtask

  task automatic test_fixed_priority();
    do_reset();
    i_read = 1; i_address = 16'h1000; d_read = 1; d_address = 16'h2000;
    for (int t = 0; t < 3; t++) begin
      step(); #1;
      total++;
      if (mem_address_fp !== 16'h2000) begin
        bad++; $display("FAIL fp_d t%0d got a=%h want 2000", t, mem_address_fp);
      end
      step(); mem_resp = 1; #1;
      total++;
      if (d_resp_fp !== 1'b1 || i_resp_fp !== 1'b0) begin
        bad++; $display("FAIL fp_resp t%0d got d=%b i=%b", t, d_resp_fp, i_resp_fp);
      end
      step(); mem_resp = 0;
      if (t == 2) d_read = 0;
    end
    step(); #1;
    total++;
    if (mem_address_fp !== 16'h1000 || mem_read_fp !== 1'b1) begin
      bad++; $display("FAIL fp_i got a=%h rd=%b want 1000/1", mem_address_fp, mem_read_fp);
    end
    step(); mem_resp = 1; step(); mem_resp = 0; i_read = 0;
  endtask

  task automatic test_protocol_errors();
    do_reset();
    i_read = 1; i_address = 16'h0300;
    step(); i_read = 0; #1;
    total++;
    if (mem_read_rr !== 1'b1 || mem_address_rr !== 16'h0300) begin
      bad++; $display("FAIL drop_hold got rd=%b a=%h want 1/0300", mem_read_rr, mem_address_rr);
    end
    step(); mem_resp = 1; mem_rdata = 16'h7777; #1;
    total++;
    if (i_resp_rr !== 1'b1 || i_rdata_rr !== 16'h7777) begin
      bad++; $display("FAIL drop_resp got r=%b d=%h want 1/7777", i_resp_rr, i_rdata_rr);
    end
    step(); mem_resp = 0; d_read = 1; d_write = 1; d_address = 16'h0400;
    step(); #1;
    total++;
    if (mem_write_rr !== 1'b1 || mem_read_rr !== 1'b0) begin
      bad++; $display("FAIL rw_both got w=%b r=%b want 1/0", mem_write_rr, mem_read_rr);
    end
    step(); mem_resp = 1; step(); mem_resp = 0; d_read = 0; d_write = 0;
  endtask

  initial begin
    test_reset();
    test_reset_mid_txn();
    test_single_fetch();
    test_byte_write();
    test_round_robin();
    test_fixed_priority();
    test_protocol_errors();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
